// File: rtl/riscv_pkg.sv
// Shared definitions for the RISC-V core: datapath width, register
// addressing and the write-back source select encoding.
package riscv_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;

  localparam logic [REG_ADDR_W-1:0] ZERO_REG = 5'd0;

  typedef enum logic {
    WB_SEL_ALU  = 1'b0,
    WB_SEL_LOAD = 1'b1
  } wb_sel_e;

endpackage

// File: rtl/regfile_2r1w.sv
// Raw register storage: one synchronous write port, two combinational
// read ports, asynchronous active-low clear. No x0 handling here; the
// write-back stage owns the architectural rules.
module regfile_2r1w
  import riscv_pkg::*;
#(
  parameter int XLEN     = riscv_pkg::XLEN,
  parameter int NUM_REGS = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we,
  input  logic [REG_ADDR_W-1:0] waddr,
  input  logic [XLEN-1:0]       wdata,
  input  logic [REG_ADDR_W-1:0] raddr1,
  input  logic [REG_ADDR_W-1:0] raddr2,
  output logic [XLEN-1:0]       rdata1,
  output logic [XLEN-1:0]       rdata2
);

  logic [XLEN-1:0] regs_q [NUM_REGS];
  logic [XLEN-1:0] regs_d [NUM_REGS];

  // Next array contents: only the addressed entry changes on a write.
  always_comb begin
    regs_d = regs_q;
    if (we && (int'(waddr) < NUM_REGS)) begin
      regs_d[waddr] = wdata;
    end
  end

  // Storage update with asynchronous clear of every entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  // Raw combinational reads; out-of-range addresses read as zero.
  always_comb begin
    rdata1 = '0;
    rdata2 = '0;
    if (int'(raddr1) < NUM_REGS) rdata1 = regs_q[raddr1];
    if (int'(raddr2) < NUM_REGS) rdata2 = regs_q[raddr2];
  end

endmodule

// File: rtl/wb_regfile_stage.sv
// Write-back stage: selects the result, commits it to the register file,
// serves the decode read ports with same-cycle bypass, and tracks the
// retired-instruction count and the last retired PC.
module wb_regfile_stage
  import riscv_pkg::*;
#(
  parameter int XLEN      = riscv_pkg::XLEN,
  parameter int NUM_REGS  = 32,
  parameter int CNT_WIDTH = 64
) (
  input  logic                 Clk,
  input  logic                 Reset_n,
  input  logic [XLEN-1:0]      Alu_Out_WB,
  input  logic [XLEN-1:0]      Loaded_Data_WB,
  input  logic [XLEN-1:0]      PC_WB,
  input  logic                 Write_Back_Control_WB,
  input  logic [4:0]           rd_WB,
  input  logic                 Write_Enable_WB,
  input  logic                 Valid_WB,
  input  logic [4:0]           rs1_ID,
  input  logic [4:0]           rs2_ID,
  output logic [XLEN-1:0]      Rs1_Data_ID,
  output logic [XLEN-1:0]      Rs2_Data_ID,
  output logic [XLEN-1:0]      Wb_Data,
  output logic                 Wb_Commit,
  output logic [CNT_WIDTH-1:0] Instret,
  output logic [XLEN-1:0]      Last_Retired_PC
);

  logic [XLEN-1:0]      rf_rdata1;
  logic [XLEN-1:0]      rf_rdata2;
  logic [CNT_WIDTH-1:0] instret_q, instret_d;
  logic [XLEN-1:0]      last_pc_q, last_pc_d;

  // Write-back source select and commit qualification (x0 never commits).
  always_comb begin
    Wb_Data   = (wb_sel_e'(Write_Back_Control_WB) == WB_SEL_LOAD) ? Loaded_Data_WB : Alu_Out_WB;
    Wb_Commit = Valid_WB & Write_Enable_WB & (rd_WB != ZERO_REG);
  end

  regfile_2r1w #(
    .XLEN     (XLEN),
    .NUM_REGS (NUM_REGS)
  ) u_regfile (
    .clk    (Clk),
    .rst_n  (Reset_n),
    .we     (Wb_Commit),
    .waddr  (rd_WB),
    .wdata  (Wb_Data),
    .raddr1 (rs1_ID),
    .raddr2 (rs2_ID),
    .rdata1 (rf_rdata1),
    .rdata2 (rf_rdata2)
  );

  // Read ports: x0 reads zero, then a committing write bypasses the array.
  always_comb begin
    if (rs1_ID == ZERO_REG)                 Rs1_Data_ID = '0;
    else if (Wb_Commit && (rs1_ID == rd_WB)) Rs1_Data_ID = Wb_Data;
    else                                    Rs1_Data_ID = rf_rdata1;

    if (rs2_ID == ZERO_REG)                 Rs2_Data_ID = '0;
    else if (Wb_Commit && (rs2_ID == rd_WB)) Rs2_Data_ID = Wb_Data;
    else                                    Rs2_Data_ID = rf_rdata2;
  end

  // Retirement bookkeeping: every valid slot retires, including x0 writes.
  always_comb begin
    instret_d = instret_q;
    last_pc_d = last_pc_q;
    if (Valid_WB) begin
      instret_d = instret_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
      last_pc_d = PC_WB;
    end
  end

  // Retirement state registers with asynchronous clear.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      instret_q <= '0;
      last_pc_q <= '0;
    end else begin
      instret_q <= instret_d;
      last_pc_q <= last_pc_d;
    end
  end

  assign Instret         = instret_q;
  assign Last_Retired_PC = last_pc_q;

endmodule
